// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a two-flop input synchronizer, mid-bit
// sampling and a single-entry AXI-Stream output register that reports
// framing errors and dropped bytes as one-cycle pulses.
module uart_rx #(
  parameter int NCLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  output logic       axis_out_tvalid,
  output logic [7:0] axis_out_tdata,
  input  logic       axis_out_tready,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CW = $clog2(NCLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(NCLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(NCLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic          rx_meta_q, rx_sync_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_done, frame_err_d;
  logic          tvalid_q, tvalid_d;
  logic [7:0]    tdata_q, tdata_d;
  logic          frame_err_q, overrun_q, overrun_d;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_data;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receive FSM state, bit-time counter and bit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Shift register holds no control meaning; every bit is rewritten per frame.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // Next-state logic: half a bit to the start-bit centre, then whole bits.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_sync_q) byte_done   = 1'b1;
          else           frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register: load when empty or being drained this cycle, else drop.
  always_comb begin
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    overrun_d = 1'b0;
    if (byte_done && (!tvalid_q || axis_out_tready)) begin
      tvalid_d = 1'b1;
      tdata_d  = shift_q;
    end else begin
      if (byte_done) overrun_d = 1'b1;
      if (tvalid_q && axis_out_tready) tvalid_d = 1'b0;
    end
  end

  // Registered outputs and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tvalid_q    <= 1'b0;
      tdata_q     <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign axis_out_tvalid = tvalid_q;
  assign axis_out_tdata  = tdata_q;
  assign rx_frame_err    = frame_err_q;
  assign rx_overrun      = overrun_q;
  assign rx_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus directed sequences for back-to-back
// frames, false start, overrun, exact-cycle drain and mid-frame reset.
module tb_uart_rx;
  localparam int N = 217;
  localparam int LAT = N / 2 + 9 * N + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_data = 1'b1;
  logic       tready = 1'b0;
  logic       tvalid, busy, ferr, ovr;
  logic [7:0] tdata;

  uart_rx #(.NCLKS_PER_BIT(N)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data),
    .axis_out_tvalid(tvalid), .axis_out_tdata(tdata),
    .axis_out_tready(tready), .rx_busy(busy),
    .rx_frame_err(ferr), .rx_overrun(ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshakes, pulse counts, pulse-width violations, tvalid rise.
  logic [7:0] rxq[$];
  int ferr_cnt = 0, ovr_cnt = 0, wide_cnt = 0, rise_cyc = -1, fall_cyc = 0;
  logic pv_ferr = 1'b0, pv_ovr = 1'b0, pv_tvalid = 1'b0;
  always @(negedge clk) begin
    if (tvalid && tready) rxq.push_back(tdata);
    if (ferr) ferr_cnt++;
    if (ovr) ovr_cnt++;
    if ((ferr && pv_ferr) || (ovr && pv_ovr) || (ferr && ovr)) wide_cnt++;
    if (tvalid && !pv_tvalid) rise_cyc = cyc;
    pv_ferr = ferr;
    pv_ovr = ovr;
    pv_tvalid = tvalid;
  end

  int tests = 0, fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic send_bit(input logic b);
    rx_data = b;
    tick(N);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb);
    rx_data = 1'b0;
    fall_cyc = cyc;
    tick(N);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stopb);
    rx_data = 1'b1;
  endtask

  task automatic clr;
    rxq.delete();
    ferr_cnt = 0;
    ovr_cnt = 0;
    rise_cyc = -1;
  endtask

  function automatic int rxv(input int i);
    if (i < rxq.size()) return int'(rxq[i]);
    return -1;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_n;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int f;
    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 8'h00, 1};
    vecs[2] = '{8'h5A, 1'b1, 1, 8'h5A, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[5] = '{8'h81, 1'b1, 1, 8'h81, 0};

    #2 rst = 1'b0;
    tick(3);
    check("reset_tvalid", int'(tvalid), 0);
    check("reset_tdata", int'(tdata), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_pulses", int'({ferr, ovr}), 0);
    rst = 1'b1;
    tick(5);
    tready = 1'b1;

    // Table-driven single frames
    for (int v = 0; v < 6; v++) begin
      clr();
      send_frame(vecs[v].data, vecs[v].stop_bit);
      tick(N / 2 + 40);
      check($sformatf("vec%0d_count", v), rxq.size(), vecs[v].exp_n);
      if (vecs[v].exp_n > 0) begin
        check($sformatf("vec%0d_data", v), rxv(0), int'(vecs[v].exp_data));
        check_rng($sformatf("vec%0d_latency", v), rise_cyc - fall_cyc, LAT - 1, LAT + 1);
      end
      check($sformatf("vec%0d_frame_err", v), ferr_cnt, vecs[v].exp_ferr);
      check($sformatf("vec%0d_overrun", v), ovr_cnt, 0);
    end

    // Back-to-back frames with no idle gap
    clr();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(N / 2 + 40);
    check("b2b_count", rxq.size(), 2);
    check("b2b_first", rxv(0), 8'h00);
    check("b2b_second", rxv(1), 8'hFF);

    // False start: low for a quarter bit
    clr();
    rx_data = 1'b0;
    f = cyc;
    tick(N / 4);
    rx_data = 1'b1;
    wait_cyc(f + 2 + N / 2);
    @(negedge clk);
    check("false_busy_during", int'(busy), 1);
    @(negedge clk);
    check("false_busy_after", int'(busy), 0);
    tick(N);
    check("false_count", rxq.size(), 0);
    check("false_frame_err", ferr_cnt, 0);

    // Overrun: consumer stalled across two frames
    clr();
    tready = 1'b0;
    send_frame(8'h11, 1'b1);
    tick(40);
    send_frame(8'h22, 1'b1);
    tick(N / 2 + 40);
    check("ovr_tvalid", int'(tvalid), 1);
    check("ovr_tdata_held", int'(tdata), 8'h11);
    check("ovr_pulses", ovr_cnt, 1);
    tready = 1'b1;
    tick(1);
    tready = 1'b0;
    tick(2);
    check("ovr_drain_count", rxq.size(), 1);
    check("ovr_drain_data", rxv(0), 8'h11);
    check("ovr_tvalid_clear", int'(tvalid), 0);

    // tready pulsed exactly in the completion cycle
    clr();
    send_frame(8'h11, 1'b1);
    tick(40);
    f = cyc;
    fork
      send_frame(8'h22, 1'b1);
      begin
        wait_cyc(f + 2 + N / 2 + 9 * N);
        tready = 1'b1;
        tick(1);
        tready = 1'b0;
      end
    join
    tick(N / 2 + 40);
    check("exact_overrun", ovr_cnt, 0);
    check("exact_popped", rxv(0), 8'h11);
    check("exact_tvalid", int'(tvalid), 1);
    check("exact_tdata", int'(tdata), 8'h22);
    tready = 1'b1;
    tick(2);
    check("exact_drain_count", rxq.size(), 2);
    check("exact_drain_data", rxv(1), 8'h22);

    // Reset during data bit 3 of 0xC3 while a byte is held
    clr();
    tready = 1'b0;
    send_frame(8'h77, 1'b1);
    tick(40);
    check("rst_pre_tvalid", int'(tvalid), 1);
    rx_data = 1'b0;
    tick(N);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rx_data = 1'b0;
    tick(N / 2);
    rst = 1'b0;
    #1;
    check("rst_tvalid", int'(tvalid), 0);
    check("rst_tdata", int'(tdata), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'({ferr, ovr}), 0);
    rx_data = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(20);
    clr();
    tready = 1'b1;
    tick(2 * N);
    check("rst_no_partial", rxq.size(), 0);
    check("rst_no_ferr", ferr_cnt, 0);
    send_frame(8'h96, 1'b1);
    tick(N / 2 + 40);
    check("rst_after_count", rxq.size(), 1);
    check("rst_after_data", rxv(0), 8'h96);

    check("pulse_width_excl", wide_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
